// File: rtl/intra_net_tiled_xpose_if.sv
// Bus bundle for the tiled intra-network transpose: configuration,
// output-buffer read port and activation-buffer write port.
interface intra_net_tiled_xpose_if #(
  parameter int DIM        = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_W     = 8
);
  localparam int CW = $clog2(DIM) + 1;
  localparam int VW = DIM * DATA_WIDTH;

  logic                  sig_start;
  logic                  mode;
  logic [CW-1:0]         A;
  logic [CW-1:0]         B;
  logic [TILE_W-1:0]     num_tiles;
  logic [ADDR_WIDTH-1:0] O_base_addr;
  logic [ADDR_WIDTH-1:0] O_stride;
  logic [ADDR_WIDTH-1:0] A_base_addr;
  logic [ADDR_WIDTH-1:0] A_stride;
  logic                  O_rd_en;
  logic [ADDR_WIDTH-1:0] O_addr;
  logic [VW-1:0]         data_in;
  logic                  wr_ready;
  logic [DIM-1:0]        A_w_en;
  logic [ADDR_WIDTH-1:0] A_addr;
  logic [VW-1:0]         data_out;
  logic                  busy;
  logic                  sig_end;

  modport master (
    output sig_start, mode, A, B, num_tiles,
    output O_base_addr, O_stride, A_base_addr, A_stride,
    output data_in, wr_ready,
    input  O_rd_en, O_addr, A_w_en, A_addr,
    input  data_out, busy, sig_end
  );

  modport slave (
    input  sig_start, mode, A, B, num_tiles,
    input  O_base_addr, O_stride, A_base_addr, A_stride,
    input  data_in, wr_ready,
    output O_rd_en, O_addr, A_w_en, A_addr,
    output data_out, busy, sig_end
  );
endinterface

// File: rtl/intra_net_tiled_xpose.sv
// Multi-tile transpose/passthrough from output buffer to activation
// buffer through a DIM x DIM register tile, with write backpressure.
module intra_net_tiled_xpose #(
  parameter int DIM        = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TILE_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  intra_net_tiled_xpose_if.slave s_bus
);
  localparam int LW = $clog2(DIM);
  localparam int CW = LW + 1;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int VW = DIM * DW;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t            r_state, w_state_d;
  logic              r_mode;
  logic [CW-1:0]     r_a, r_b;
  logic [TILE_W-1:0] r_nt, r_t;
  logic [AW-1:0]     r_ostr, r_astr, r_obase, r_abase;
  logic [AW-1:0]     r_raddr, r_waddr;
  logic [LW-1:0]     r_row, r_k, r_cap_row;
  logic              r_cap_en, r_busy, r_end;
  logic [DIM-1:0]    r_wen;
  logic [VW-1:0]     r_wdata;
  logic [VW-1:0]     r_buf [DIM];

  logic [CW-1:0]     w_a_sat, w_b_sat, w_klen;
  logic              w_zero, w_last_row, w_last_k;
  logic              w_last_t, w_load;
  logic [LW-1:0]     w_kn;
  logic [VW-1:0]     w_buf [DIM];
  logic [VW-1:0]     w_wdata;
  logic [DIM-1:0]    w_wen;

  assign w_a_sat = (s_bus.A > CW'(DIM)) ? CW'(DIM) : s_bus.A;
  assign w_b_sat = (s_bus.B > CW'(DIM)) ? CW'(DIM) : s_bus.B;
  assign w_zero  = (s_bus.A == '0) || (s_bus.B == '0)
                || (s_bus.num_tiles == '0);

  assign w_klen     = r_mode ? r_a : r_b;
  assign w_last_row = ({1'b0, r_row} == r_a - CW'(1));
  assign w_last_k   = ({1'b0, r_k} == w_klen - CW'(1));
  assign w_last_t   = (r_t == r_nt - TILE_W'(1));
  assign w_kn       = (r_state == S_WRITE) ? r_k + LW'(1) : '0;
  assign w_load     = (r_state == S_DRAIN)
                   || (r_state == S_WRITE && s_bus.wr_ready && !w_last_k);

  // Last row lands in the tile on the same edge that loads write 0
  always_comb begin
    for (int i = 0; i < DIM; i++)
      w_buf[i] = (r_cap_en && r_cap_row == LW'(i))
               ? s_bus.data_in : r_buf[i];
  end

  always_comb begin
    w_wdata = '0;
    w_wen   = '0;
    for (int j = 0; j < DIM; j++) begin
      if (r_mode) begin
        if (j < int'(r_b)) begin
          w_wen[j] = 1'b1;
          w_wdata[j*DW +: DW] = w_buf[w_kn][j*DW +: DW];
        end
      end else if (j < int'(r_a)) begin
        w_wen[j] = 1'b1;
        w_wdata[j*DW +: DW] = w_buf[j][int'(w_kn)*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:
        if (s_bus.sig_start)
          w_state_d = w_zero ? S_DONE : S_READ;
      S_READ:
        if (w_last_row) w_state_d = S_DRAIN;
      S_DRAIN: w_state_d = S_WRITE;
      S_WRITE:
        if (s_bus.wr_ready && w_last_k)
          w_state_d = w_last_t ? S_DONE : S_NEXT;
      S_NEXT:  w_state_d = S_READ;
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_nt      <= '0;
      r_t       <= '0;
      r_ostr    <= '0;
      r_astr    <= '0;
      r_obase   <= '0;
      r_abase   <= '0;
      r_raddr   <= '0;
      r_waddr   <= '0;
      r_row     <= '0;
      r_k       <= '0;
      r_cap_row <= '0;
      r_cap_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_end     <= 1'b0;
      r_wen     <= '0;
      r_wdata   <= '0;
    end else begin
      r_cap_en  <= (r_state == S_READ);
      r_cap_row <= r_row;
      r_end     <= (r_state == S_DONE);
      if (r_state == S_IDLE && s_bus.sig_start) begin
        r_mode  <= s_bus.mode;
        r_a     <= w_a_sat;
        r_b     <= w_b_sat;
        r_nt    <= s_bus.num_tiles;
        r_ostr  <= s_bus.O_stride;
        r_astr  <= s_bus.A_stride;
        r_obase <= s_bus.O_base_addr;
        r_raddr <= s_bus.O_base_addr;
        r_abase <= s_bus.A_base_addr;
        r_row   <= '0;
        r_t     <= '0;
        r_busy  <= 1'b1;
      end
      if (r_state == S_READ) begin
        r_row   <= r_row + LW'(1);
        r_raddr <= r_raddr + AW'(1);
      end
      if (r_state == S_NEXT) begin
        r_t     <= r_t + TILE_W'(1);
        r_obase <= r_obase + r_ostr;
        r_raddr <= r_obase + r_ostr;
        r_abase <= r_abase + r_astr;
        r_row   <= '0;
      end
      if (r_state == S_DONE) r_busy <= 1'b0;
      // Without wr_ready the beat on the bus is simply held
      if (w_load) begin
        r_k     <= w_kn;
        r_wen   <= w_wen;
        r_wdata <= w_wdata;
        r_waddr <= r_abase + AW'(w_kn);
      end else if (r_state == S_WRITE && s_bus.wr_ready) begin
        r_wen   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_cap_en) r_buf[r_cap_row] <= s_bus.data_in;
  end

  assign s_bus.O_rd_en  = (r_state == S_READ);
  assign s_bus.O_addr   = r_raddr;
  assign s_bus.A_w_en   = r_wen;
  assign s_bus.A_addr   = r_waddr;
  assign s_bus.data_out = r_wdata;
  assign s_bus.busy     = r_busy;
  assign s_bus.sig_end  = r_end;
endmodule

// File: tb/tb_intra_net_tiled_xpose.sv
// Bench for intra_net_tiled_xpose: memory model plus expected
// read/write streams built from the tile rules.
module tb_intra_net_tiled_xpose;
  localparam int DIM = 4;
  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int TW  = 8;
  localparam int CW  = $clog2(DIM) + 1;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [DIM-1:0]    wen;
    logic [DIM*DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  intra_net_tiled_xpose_if #(
    .DIM(DIM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TILE_W(TW)
  ) bus ();

  intra_net_tiled_xpose #(
    .DIM(DIM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TILE_W(TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_bus (bus.slave)
  );

  logic [31:0]   omem [1024];
  logic [31:0]   amem [1024];
  logic [31:0]   snap [12];
  logic [AW-1:0] exp_rd [$];
  logic [AW-1:0] rd_log [$];
  wr_t           exp_wr [$];
  wr_t           wr_log [$];

  int n_checks = 0;
  int n_errors = 0;
  int n_end = 0;
  bit stall_mode = 1'b0;
  int stall_cnt = 0;
  bit pend_en = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  bit prev_stall = 1'b0;
  wr_t prev_w;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.O_rd_en, bus.O_addr, bus.A_w_en, bus.A_addr,
                bus.data_out, bus.busy, bus.sig_end});
  endfunction

  // Memory responder, ready generator and per-cycle compare
  always @(negedge clk) begin
    wr_t w, e;
    bus.data_in = pend_en ? omem[pend_addr] : 32'hA5A5A5A5;
    pend_en = bus.O_rd_en;
    pend_addr = bus.O_addr;
    if (stall_mode && bus.A_w_en != '0) begin
      if (stall_cnt < 2) begin
        bus.wr_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.wr_ready = 1'b1;
        stall_cnt = 0;
      end
    end else begin
      bus.wr_ready = 1'b1;
    end
    w.addr = bus.A_addr;
    w.wen  = bus.A_w_en;
    w.data = bus.data_out;
    if (!reset) begin
      if (prev_stall)
        chk("hold", {w.wen, w.addr, w.data},
            {prev_w.wen, prev_w.addr, prev_w.data});
      if (bus.O_rd_en) begin
        rd_log.push_back(bus.O_addr);
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0)
          chk("rd_addr", bus.O_addr, exp_rd.pop_front());
      end
      if (w.wen != '0 && bus.wr_ready) begin
        wr_log.push_back(w);
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_beat", {w.wen, w.addr, w.data},
              {e.wen, e.addr, e.data});
        end
        for (int j = 0; j < DIM; j++)
          if (w.wen[j]) amem[w.addr][j*DW +: DW] = w.data[j*DW +: DW];
      end
      if (bus.sig_end) n_end++;
    end
    prev_stall = !reset && w.wen != '0 && !bus.wr_ready;
    prev_w = w;
  end

  task automatic build_model(input bit md, input int a, b, nt,
                             input int ob, ostr, ab, astr);
    int ae, be, kl, obt, abt;
    logic [DW-1:0] e [DIM][DIM];
    logic [31:0] row;
    wr_t w;
    ae = (a > DIM) ? DIM : a;
    be = (b > DIM) ? DIM : b;
    if (ae == 0 || be == 0 || nt == 0) return;
    for (int t = 0; t < nt; t++) begin
      obt = ob + t * ostr;
      abt = ab + t * astr;
      for (int r = 0; r < ae; r++) begin
        exp_rd.push_back(AW'(obt + r));
        row = omem[AW'(obt + r)];
        for (int c = 0; c < DIM; c++) e[r][c] = row[c*DW +: DW];
      end
      kl = md ? ae : be;
      for (int k = 0; k < kl; k++) begin
        w.addr = AW'(abt + k);
        w.wen  = '0;
        w.data = '0;
        for (int j = 0; j < DIM; j++) begin
          if (!md && j < ae) begin
            w.wen[j] = 1'b1;
            w.data[j*DW +: DW] = e[j][k];
          end
          if (md && j < be) begin
            w.wen[j] = 1'b1;
            w.data[j*DW +: DW] = e[k][j];
          end
        end
        exp_wr.push_back(w);
      end
    end
  endtask

  task automatic drive(input bit md, input int a, b, nt,
                       input int ob, ostr, ab, astr);
    bus.mode        = md;
    bus.A           = CW'(a);
    bus.B           = CW'(b);
    bus.num_tiles   = TW'(nt);
    bus.O_base_addr = AW'(ob);
    bus.O_stride    = AW'(ostr);
    bus.A_base_addr = AW'(ab);
    bus.A_stride    = AW'(astr);
  endtask

  task automatic clear_amem();
    for (int i = 0; i < 1024; i++) amem[i] = '0;
  endtask

  task automatic run_job(input bit md, input int a, b, nt,
                         input int ob, ostr, ab, astr,
                         input bit stall, input int lat,
                         input int xs_at);
    int cyc;
    build_model(md, a, b, nt, ob, ostr, ab, astr);
    stall_mode = stall;
    stall_cnt = 0;
    n_end = 0;
    rd_log.delete();
    wr_log.delete();
    @(negedge clk);
    drive(md, a, b, nt, ob, ostr, ab, astr);
    bus.sig_start = 1'b1;
    @(negedge clk);
    bus.sig_start = 1'b0;
    cyc = 1;
    chk("busy_after_start", bus.busy, 1);
    while (!bus.sig_end && cyc < 3000) begin
      bus.sig_start = (cyc == xs_at);
      if (cyc == xs_at) begin
        bus.mode = ~md;
        bus.A = CW'(1);
      end
      @(negedge clk);
      cyc++;
    end
    bus.sig_start = 1'b0;
    chk("end_seen", bus.sig_end, 1);
    if (lat > 0) chk("end_latency", cyc, lat);
    chk("busy_at_end", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("end_count", n_end, 1);
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    stall_mode = 1'b0;
  endtask

  initial begin
    int rd_n;
    bit found;
    bus.sig_start = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++)
      omem[i] = {8'(i + 3), 8'(i * 5), 8'(i ^ 8'h5A), 8'(i * 3 + 1)};
    omem['h10] = 32'h04030201;
    omem['h11] = 32'h08070605;
    omem['h12] = 32'h0C0B0A09;
    clear_amem();
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;

    // transpose, 3 rows x 2 cols
    run_job(0, 3, 2, 1, 'h10, 0, 'h40, 0, 0, 8, -1);
    chk("t1_rd_cnt", rd_log.size(), 3);
    chk("t1_rd0", rd_log[0], 'h10);
    chk("t1_wen", wr_log[0].wen, 4'b0111);
    chk("t1_m40", amem['h40], 32'h00090501);
    chk("t1_m41", amem['h41], 32'h000A0602);
    chk("t1_m42", amem['h42], 32'h0);

    // passthrough, same data
    clear_amem();
    run_job(1, 3, 2, 1, 'h10, 0, 'h40, 0, 0, 9, -1);
    chk("t2_wen", wr_log[0].wen, 4'b0011);
    chk("t2_m40", amem['h40], 32'h00000201);
    chk("t2_m41", amem['h41], 32'h00000605);
    chk("t2_m42", amem['h42], 32'h00000A09);

    // three tiles with strides
    clear_amem();
    run_job(0, 4, 4, 3, 'h10, 8, 'h40, 4, 0, 31, -1);
    chk("t3_rd0", rd_log[0], 'h10);
    chk("t3_rd4", rd_log[4], 'h18);
    chk("t3_rd8", rd_log[8], 'h20);
    chk("t3_wr0", wr_log[0].addr, 'h40);
    chk("t3_wr4", wr_log[4].addr, 'h44);
    chk("t3_wr8", wr_log[8].addr, 'h48);
    for (int i = 0; i < 12; i++) snap[i] = amem['h40 + i];

    // same job, every write stalled twice
    clear_amem();
    run_job(0, 4, 4, 3, 'h10, 8, 'h40, 4, 1, 55, -1);
    for (int i = 0; i < 12; i++)
      chk("stall_mem", amem['h40 + i], snap[i]);

    // empty jobs
    run_job(0, 0, 2, 1, 'h10, 0, 'h40, 0, 0, 2, -1);
    run_job(0, 3, 2, 0, 'h10, 0, 'h40, 0, 0, 2, -1);

    // start pulsed while busy is ignored
    clear_amem();
    run_job(0, 3, 2, 1, 'h10, 0, 'h40, 0, 0, 8, 3);
    chk("xs_m40", amem['h40], 32'h00090501);

    // address wrap, A saturates to DIM
    run_job(0, 7, 4, 1, 'h3FE, 0, 'h3FE, 0, 0, 11, -1);
    chk("wrap_cnt", rd_log.size(), 4);
    chk("wrap_rd0", rd_log[0], 'h3FE);
    chk("wrap_rd1", rd_log[1], 'h3FF);
    chk("wrap_rd2", rd_log[2], 'h000);
    chk("wrap_rd3", rd_log[3], 'h001);
    chk("wrap_wr2", wr_log[2].addr, 'h000);

    // reset in the middle of WRITE
    build_model(0, 4, 4, 1, 'h20, 0, 'h80, 0);
    n_end = 0;
    rd_log.delete();
    wr_log.delete();
    @(negedge clk);
    drive(0, 4, 4, 1, 'h20, 0, 'h80, 0);
    bus.sig_start = 1'b1;
    @(negedge clk);
    bus.sig_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      found = (bus.A_w_en != '0);
    end
    chk("reached_write", found, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_outputs", outs(), 0);
    rd_n = rd_log.size();
    repeat (6) @(negedge clk);
    chk("rst_no_end", n_end, 0);
    chk("rst_no_reads", rd_log.size(), rd_n);
    chk("rst_busy", bus.busy, 0);
    exp_rd.delete();
    exp_wr.delete();

    // fresh job after abort
    clear_amem();
    run_job(0, 3, 2, 1, 'h10, 0, 'h40, 0, 0, 8, -1);
    chk("post_m41", amem['h41], 32'h000A0602);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/intra_net_tiled_xpose.md
Name: intra_net_tiled_xpose

Overview:
Multi-tile successor to the intra-network transpose/address-generator pair. It reads output-buffer rows, stages them in an internal DIM x DIM register tile, and writes them to the activation buffer either transposed or passed through. One start processes NUM_TILES tiles with per-tile base-address strides. Activation writes honour a wr_ready backpressure input.

Parameters:
DIM, 16, lanes per vector and tile edge (power of two, >=2)
DATA_WIDTH, 8, bits per lane
ADDR_WIDTH, 10, buffer address width
TILE_W, 8, width of tile count

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
sig_start  in  1  one-cycle start pulse; sampled only in IDLE
mode  in  1  0 = transpose, 1 = passthrough
A  in  $clog2(DIM)+1  valid rows per tile
B  in  $clog2(DIM)+1  valid columns per tile
num_tiles  in  TILE_W  tiles to process
O_base_addr  in  ADDR_WIDTH  first source row address
O_stride  in  ADDR_WIDTH  source address step per tile
A_base_addr  in  ADDR_WIDTH  first destination address
A_stride  in  ADDR_WIDTH  destination address step per tile
O_rd_en  out  1  output-buffer read strobe
O_addr  out  ADDR_WIDTH  output-buffer read address
data_in  in  DIM*DATA_WIDTH  read data, lane j at bits [j*DATA_WIDTH +: DATA_WIDTH]
wr_ready  in  1  activation buffer accepts the write this cycle
A_w_en  out  DIM  per-lane write enable
A_addr  out  ADDR_WIDTH  activation write address
data_out  out  DIM*DATA_WIDTH  write data
busy  out  1  high from the cycle after an accepted start until sig_end
sig_end  out  1  one-cycle done pulse

Behaviour:
- Clock is clk. Reset is synchronous and active-high. Reset forces IDLE and drives every output to 0. Tile buffer contents are don't-care after reset. Reset mid-operation aborts immediately with no further reads or writes.
- On sig_start in IDLE, latch all configuration inputs. A and B saturate to DIM. sig_start outside IDLE is ignored.
- States: IDLE -> READ -> DRAIN -> WRITE -> (NEXT -> READ | DONE) -> IDLE.
- If A==0, B==0 or num_tiles==0: IDLE -> DONE. No O_rd_en and no A_w_en are issued. sig_end pulses 2 cycles after start.
- READ, for r = 0..A-1, one per cycle: O_rd_en=1, O_addr = O_base + t*O_stride + r, where t is the tile index. data_in is valid exactly 1 cycle after its read strobe and is captured into buf row r.
- DRAIN: a single cycle that captures the last row.
- WRITE, for k = 0..K-1:
  - Transpose: K=B, data_out lane j = buf[j][k] for j<A, else 0; A_w_en = lanes 0..A-1 set.
  - Passthrough: K=A, data_out lane j = buf[k][j] for j<B, else 0; A_w_en = lanes 0..B-1 set.
  - A_addr = A_base + t*A_stride + k.
  - Outputs are registered. A write completes in a cycle where A_w_en!=0 and wr_ready=1.
  - If wr_ready=0, hold A_w_en, A_addr and data_out unchanged; this is unbounded stall-safe.
  - A_w_en=0 outside WRITE.
- NEXT: one cycle, t increments. After the last tile the FSM goes to DONE. DONE pulses sig_end for one cycle, then returns to IDLE and busy drops in that same cycle.
- Zero stall, transpose, per tile: A read cycles + 1 drain + B write cycles + 1 NEXT/DONE cycle.
- All address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is legal and silent.
- A new start is accepted in the cycle after sig_end.

Test Plan:
- DIM=4, mode=0, A=3, B=2, num_tiles=1, O_base=0x10, A_base=0x40, rows {1,2,3,4},{5,6,7,8},{9,10,11,12}: reads 0x10..0x12 -> writes 0x40 = {1,5,9,0}, 0x41 = {2,6,10,0}, A_w_en=4'b0111, sig_end once, busy low after.
- Same data, mode=1, B=2: three writes at 0x40..0x42 = {1,2,0,0},{5,6,0,0},{9,10,0,0}; A_w_en=4'b0011.
- num_tiles=3, O_stride=8, A_stride=4, A=B=4: reads start at 0x10/0x18/0x20, writes at 0x40/0x44/0x48; each tile is a correct transpose; single sig_end.
- wr_ready toggled 0,0,1 on every write: each write is held for 2 stall cycles with stable addr/data; final memory matches the no-stall run.
- A=0, then num_tiles=0: no O_rd_en or A_w_en; sig_end 2 cycles after start. sig_start pulsed while busy is ignored.
- O_base=0x3FE, A=4 (ADDR_WIDTH=10): reads 0x3FE,0x3FF,0x000,0x001. reset asserted mid-WRITE: next cycle all outputs 0, FSM in IDLE, no sig_end.
